uart_cordic_ctrl: RTL and testbench
===================================

# uart_cordic_ctrl

Frame-level controller between the UART receiver/transmitter pair and the CORDIC exponential core. It assembles a checksummed operand frame from received bytes, launches one CORDIC evaluation, waits for completion, and streams the result back through the UART transmitter. It is the only block that drives the CORDIC start and the transmitter start, so it sequences the whole host-to-core transaction.

## Interface
- `W`, 32: CORDIC operand/result width in bits. Must be a multiple of 8; NB = W/8 bytes per word.
- `TIMEOUT_TICKS`, 16*12*4: maximum number of `s_tick` pulses allowed between received bytes inside a frame.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `s_tick`  in  1  baud-rate oversampling tick, 16 per bit; used only by the timeout counter.
- `rx_done_tick`  in  1  one-cycle pulse; `rx_dout` is valid on that cycle.
- `rx_dout`  in  8  received byte.
- `tx_done_tick`  in  1  one-cycle pulse; the transmitter has finished the current byte.
- `tx_start`  out  1  one-cycle pulse that launches transmission of `tx_din`.
- `tx_din`  out  8  byte to transmit; held stable from `tx_start` until `tx_done_tick`.
- `cordic_start`  out  1  one-cycle pulse that launches a CORDIC evaluation.
- `cordic_operand`  out  W  operand; stable from `cordic_start` until the next accepted frame.
- `cordic_done`  in  1  one-cycle pulse; `cordic_result` is valid on that cycle.
- `cordic_result`  in  W  CORDIC result.
- `busy`  out  1  high in every state except IDLE.
- `frame_err`  out  1  one-cycle pulse on a checksum error or a timeout.

## Operation
- Frame format: SYNC=0xA5, then NB operand bytes LSB first, then CHK = XOR of the operand bytes. SYNC is excluded from CHK.
- Reply on a good frame: ACK=0x5A, then NB result bytes LSB first. Reply on a bad CHK: the single byte NAK=0xEE. A timeout produces no reply.
- States:
  - IDLE: on `rx_done_tick` with byte 0xA5, clear the byte index and checksum, then go to RX_OPND. Any other byte is ignored.
  - RX_OPND: on each byte, shift it into the operand shadow at position index×8 and XOR it into the checksum. After byte NB−1, go to RX_CHK.
  - RX_CHK: on a byte equal to the checksum, copy the shadow to `cordic_operand` and go to RUN. On a mismatch, pulse `frame_err`, load NAK, and go to TX_LOAD with the reply length set to 1.
  - RUN: assert `cordic_start` for exactly one cycle, then go to WAIT.
  - WAIT: on `cordic_done`, latch `cordic_result`, load ACK, set the reply length to NB+1, and go to TX_LOAD.
  - TX_LOAD: pulse `tx_start` with `tx_din` valid, then go to TX_WAIT.
  - TX_WAIT: on `tx_done_tick`, increment the tx index. If tx index equals the reply length, go to IDLE. Otherwise load result byte (index−1) into `tx_din` and return to TX_LOAD.
- Timeout:
  - In RX_OPND and RX_CHK a counter increments on each `s_tick` and clears on each `rx_done_tick`.
  - When the counter reaches TIMEOUT_TICKS−1 and an `s_tick` arrives, pulse `frame_err` and go to IDLE.
  - If `rx_done_tick` and the expiring `s_tick` arrive on the same cycle, the byte wins and no timeout occurs.
- `rx_done_tick` in RUN, WAIT, TX_LOAD or TX_WAIT is dropped; there is no buffering.
- An extra `cordic_done` outside WAIT is ignored.
- A SYNC value inside the operand or checksum field is treated as data; the controller does not resynchronise on it.

## Timing
- Reset, sampled on a rising edge of `clk`: state goes to IDLE. `tx_start`, `cordic_start`, `frame_err`, `busy` = 0. `tx_din` = 0x00. `cordic_operand` and the result register = 0. All counters = 0.
- Reset asserted mid-frame or mid-reply aborts immediately; no further tx byte is started.
- `cordic_start` is high in the cycle after the cycle that samples the matching CHK byte.
- `tx_start` for ACK is high in the cycle after the TX_LOAD entry cycle, i.e. 2 cycles after `cordic_done`.
- The gap between `tx_done_tick` and the next `tx_start` is 2 cycles.
- All outputs are registered. Pulses are exactly one cycle wide.

## Structure
- Shared package `uart_cordic_pkg`:
  - state encoding: 3 bits, 7 states.
  - SYNC, ACK, NAK byte constants.
  - a function for the timeout counter width, clog2(TIMEOUT_TICKS).
- One natural sub-module: `byte_word_shifter`. It provides W-bit byte-indexed insert for receive and byte-indexed extract for transmit, and is instantiated twice (operand shadow and result).

## Test plan
- Good frame, W=32: rx A5 78 56 34 12 08.
  - `cordic_operand`=0x12345678 and one `cordic_start` pulse.
  - Return `cordic_result`=0xCAFEBABE; tx sequence is 5A BE BA FE CA.
  - `busy` falls after the 5th `tx_done_tick`.
- Bad checksum: rx A5 78 56 34 12 09.
  - One `frame_err` pulse, tx 0xEE only, and no `cordic_start`.
- Noise in IDLE: rx 00 FF 5A before A5 and a good frame.
  - Exactly one transaction occurs and `busy` stays low until A5 is received.
- Timeout: rx A5 78, then no byte for TIMEOUT_TICKS `s_tick` pulses.
  - `frame_err` pulses, state returns to IDLE, nothing is transmitted.
  - A following good frame is processed normally.
  - Also check the same-cycle case: byte and expiring tick together must not time out.
- Reset mid-reply: assert `reset` for one cycle after ACK's `tx_done_tick`.
  - All outputs take their reset values the next cycle and no further `tx_start` occurs.
- Dropped traffic: inject `rx_done_tick` during WAIT and a spurious `cordic_done` during RX_OPND.
  - Both are ignored and the result bytes are unchanged.

Source files
------------

// File: rtl/uart_cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cordic_pkg
// Description : Shared types and constants for the UART/CORDIC frame
//               controller: FSM state encoding, protocol byte values and
//               the timeout counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cordic_pkg;

    // Controller states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_OPND = 3'd1,
        ST_RX_CHK  = 3'd2,
        ST_RUN     = 3'd3,
        ST_WAIT    = 3'd4,
        ST_TX_LOAD = 3'd5,
        ST_TX_WAIT = 3'd6
    } state_t;

    // Protocol bytes
    localparam logic [7:0] c_sync_byte = 8'hA5;
    localparam logic [7:0] c_ack_byte  = 8'h5A;
    localparam logic [7:0] c_nak_byte  = 8'hEE;

    // Bits needed to count 0 .. ticks-1 (never less than one bit)
    function automatic int tmo_cnt_width(input int ticks);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < ticks) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_word_shifter.sv
`default_nettype none
// ============================================================================
// Module      : byte_word_shifter
// Description : Byte-indexed access to a W-bit word. o_word is i_word with
//               byte lane i_byte_idx replaced by i_byte; o_byte is byte lane
//               i_byte_idx of i_word. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_word_shifter #(
    parameter int W     = 32,
    parameter int IDX_W = 3
) (
    input  logic [W-1:0]     i_word,
    input  logic [IDX_W-1:0] i_byte_idx,
    input  logic [7:0]       i_byte,
    output logic [W-1:0]     o_word,
    output logic [7:0]       o_byte
);

    localparam int NB = W / 8;

    // Insert path: each lane either keeps its value or takes the new byte
    genvar k;
    generate
        for (k = 0; k < NB; k++) begin : g_lane
            assign o_word[k*8 +: 8] = (i_byte_idx == IDX_W'(k)) ? i_byte : i_word[k*8 +: 8];
        end
    endgenerate

    // Extract path: select the addressed lane, zero when out of range
    always_comb begin
        o_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (i_byte_idx == IDX_W'(i)) begin
                o_byte = i_word[i*8 +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cordic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cordic_ctrl
// Description : Frame controller between the UART rx/tx pair and the CORDIC
//               exponential core. Receives SYNC + operand + XOR checksum,
//               launches one CORDIC run and replies ACK + result (or NAK on
//               a checksum error). Inter-byte timeout aborts silently.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cordic_ctrl
    import uart_cordic_pkg::*;
#(
    parameter int W             = 32,
    parameter int TIMEOUT_TICKS = 16*12*4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_tick,
    input  logic         rx_done_tick,
    input  logic [7:0]   rx_dout,
    input  logic         tx_done_tick,
    output logic         tx_start,
    output logic [7:0]   tx_din,
    output logic         cordic_start,
    output logic [W-1:0] cordic_operand,
    input  logic         cordic_done,
    input  logic [W-1:0] cordic_result,
    output logic         busy,
    output logic         frame_err
);

    localparam int NB    = W / 8;
    // Index must reach NB+1 (reply length including ACK)
    localparam int IDX_W = $clog2(NB + 2);
    localparam int TMO_W = tmo_cnt_width(TIMEOUT_TICKS);

    state_t             r_state;
    logic [IDX_W-1:0]   r_rx_idx;
    logic [IDX_W-1:0]   r_tx_idx;
    logic [IDX_W-1:0]   r_reply_len;
    logic [7:0]         r_chk;
    logic [W-1:0]       r_shadow;
    logic [W-1:0]       r_operand;
    logic [W-1:0]       r_result;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [7:0]         r_tx_din;
    logic               r_tx_start;
    logic               r_cordic_start;
    logic               r_frame_err;
    logic               r_busy;

    logic [W-1:0]       w_shadow_ins;
    logic [7:0]         w_tx_byte;
    logic [W-1:0]       w_unused_res_word;
    logic [7:0]         w_unused_shadow_byte;
    logic [IDX_W-1:0]   w_rx_idx_nxt;
    logic [IDX_W-1:0]   w_tx_idx_nxt;
    logic               w_tmo_last;

    assign w_rx_idx_nxt = r_rx_idx + 1'b1;
    assign w_tx_idx_nxt = r_tx_idx + 1'b1;
    assign w_tmo_last   = (r_tmo_cnt == TMO_W'(TIMEOUT_TICKS - 1));

    // Operand shadow: drop the incoming byte into lane r_rx_idx
    byte_word_shifter #(.W(W), .IDX_W(IDX_W)) u_opnd_shifter (
        .i_word     (r_shadow),
        .i_byte_idx (r_rx_idx),
        .i_byte     (rx_dout),
        .o_word     (w_shadow_ins),
        .o_byte     (w_unused_shadow_byte)
    );

    // Result: the pre-increment tx index addresses the next result byte
    byte_word_shifter #(.W(W), .IDX_W(IDX_W)) u_res_shifter (
        .i_word     (r_result),
        .i_byte_idx (r_tx_idx),
        .i_byte     (8'h00),
        .o_word     (w_unused_res_word),
        .o_byte     (w_tx_byte)
    );

    // Frame sequencer with registered outputs and inter-byte timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_rx_idx       <= '0;
            r_tx_idx       <= '0;
            r_reply_len    <= '0;
            r_chk          <= 8'h00;
            r_shadow       <= '0;
            r_operand      <= '0;
            r_result       <= '0;
            r_tmo_cnt      <= '0;
            r_tx_din       <= 8'h00;
            r_tx_start     <= 1'b0;
            r_cordic_start <= 1'b0;
            r_frame_err    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_tx_start     <= 1'b0;
            r_cordic_start <= 1'b0;
            r_frame_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tmo_cnt <= '0;
                    if (rx_done_tick && (rx_dout == c_sync_byte)) begin
                        r_rx_idx <= '0;
                        r_chk    <= 8'h00;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RX_OPND;
                    end
                end
                ST_RX_OPND: begin
                    // A received byte takes priority over an expiring tick
                    if (rx_done_tick) begin
                        r_tmo_cnt <= '0;
                        r_shadow  <= w_shadow_ins;
                        r_chk     <= r_chk ^ rx_dout;
                        r_rx_idx  <= w_rx_idx_nxt;
                        if (r_rx_idx == IDX_W'(NB - 1)) begin
                            r_state <= ST_RX_CHK;
                        end
                    end else if (s_tick) begin
                        if (w_tmo_last) begin
                            r_frame_err <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end
                end
                ST_RX_CHK: begin
                    if (rx_done_tick) begin
                        r_tmo_cnt <= '0;
                        if (rx_dout == r_chk) begin
                            r_operand      <= r_shadow;
                            r_cordic_start <= 1'b1;
                            r_state        <= ST_RUN;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_tx_din    <= c_nak_byte;
                            r_reply_len <= IDX_W'(1);
                            r_tx_idx    <= '0;
                            r_state     <= ST_TX_LOAD;
                        end
                    end else if (s_tick) begin
                        if (w_tmo_last) begin
                            r_frame_err <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cordic_done) begin
                        r_result    <= cordic_result;
                        r_tx_din    <= c_ack_byte;
                        r_reply_len <= IDX_W'(NB + 1);
                        r_tx_idx    <= '0;
                        r_state     <= ST_TX_LOAD;
                    end
                end
                ST_TX_LOAD: begin
                    r_tx_start <= 1'b1;
                    r_state    <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (tx_done_tick) begin
                        r_tx_idx <= w_tx_idx_nxt;
                        if (w_tx_idx_nxt == r_reply_len) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_tx_din <= w_tx_byte;
                            r_state  <= ST_TX_LOAD;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_start       = r_tx_start;
    assign tx_din         = r_tx_din;
    assign cordic_start   = r_cordic_start;
    assign cordic_operand = r_operand;
    assign busy           = r_busy;
    assign frame_err      = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cordic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cordic_ctrl
// Description : Self-checking bench for uart_cordic_ctrl. Table of complete
//               frames plus directed sequences for noise, timeout, dropped
//               traffic and reset during a reply. Simple CORDIC and UART
//               transmitter responders close the loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cordic_ctrl;

    localparam int c_w          = 32;
    localparam int c_tmo        = 16;
    localparam int c_cordic_lat = 3;
    localparam int c_tx_lat     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_tick;
    logic        rx_done_tick;
    logic [7:0]  rx_dout;
    logic        tx_done_tick = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        cordic_start;
    logic [31:0] cordic_operand;
    logic        cordic_done;
    logic [31:0] cordic_result;
    logic        busy;
    logic        frame_err;
    logic        m_cdone = 1'b0;
    logic        inj_cdone;

    assign cordic_done = m_cdone | inj_cdone;

    uart_cordic_ctrl #(.W(c_w), .TIMEOUT_TICKS(c_tmo)) dut (
        .clk            (clk),
        .reset          (reset),
        .s_tick         (s_tick),
        .rx_done_tick   (rx_done_tick),
        .rx_dout        (rx_dout),
        .tx_done_tick   (tx_done_tick),
        .tx_start       (tx_start),
        .tx_din         (tx_din),
        .cordic_start   (cordic_start),
        .cordic_operand (cordic_operand),
        .cordic_done    (cordic_done),
        .cordic_result  (cordic_result),
        .busy           (busy),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int last_rx_cyc = -100;
    int last_evt_cyc = -100;
    int last_txdone_cyc = -100;
    int n_start = 0;
    int n_err = 0;
    int n_txdone = 0;
    logic prev_cstart = 1'b0;
    logic prev_txstart = 1'b0;
    logic prev_ferr = 1'b0;
    logic [7:0] txq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pulse counts, pulse widths, latencies, tx byte capture
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cordic_start) begin
            n_start++;
            check("cordic_start_latency", 64'(cyc - last_rx_cyc), 64'd1);
            check("cordic_start_width", {63'd0, prev_cstart}, 64'd0);
        end
        if (tx_start) begin
            txq.push_back(tx_din);
            check("tx_start_gap", 64'(cyc - last_evt_cyc), 64'd2);
            check("tx_start_width", {63'd0, prev_txstart}, 64'd0);
        end
        if (tx_done_tick && txq.size() > 0) begin
            check("tx_din_stable", {56'd0, tx_din}, {56'd0, txq[txq.size()-1]});
        end
        if (frame_err) begin
            n_err++;
            check("frame_err_width", {63'd0, prev_ferr}, 64'd0);
        end
        if (rx_done_tick) begin
            last_rx_cyc  = cyc;
            last_evt_cyc = cyc;
        end
        if (cordic_done) last_evt_cyc = cyc;
        if (tx_done_tick) begin
            last_txdone_cyc = cyc;
            last_evt_cyc    = cyc;
            n_txdone++;
        end
        prev_cstart  = cordic_start;
        prev_txstart = tx_start;
        prev_ferr    = frame_err;
    end

    // CORDIC responder: done pulse c_cordic_lat cycles after start
    always begin
        @(posedge clk);
        if (cordic_start) begin
            repeat (c_cordic_lat - 1) @(posedge clk);
            #1 m_cdone = 1'b1;
            @(posedge clk);
            #1 m_cdone = 1'b0;
        end
    end

    // UART transmitter responder: done pulse c_tx_lat cycles after start
    always begin
        @(posedge clk);
        if (tx_start) begin
            repeat (c_tx_lat - 1) @(posedge clk);
            #1 tx_done_tick = 1'b1;
            @(posedge clk);
            #1 tx_done_tick = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_dout      = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8]);
    endtask

    // Wait for the reply to finish; busy must fall on the last tx_done edge
    task automatic wait_idle(input string tag);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
        check({tag, "_busy_fall"}, 64'(cyc), 64'(last_txdone_cyc));
    endtask

    task automatic check_reply(input string tag, input int base, input logic [39:0] expv, input int n);
        logic [7:0] got;
        check({tag, "_txcount"}, 64'(txq.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            got = (base + i < txq.size()) ? txq[base+i] : 8'hxx;
            check($sformatf("%s_txbyte%0d", tag, i), {56'd0, got}, {56'd0, expv[39-8*i -: 8]});
        end
    endtask

    typedef struct {
        logic [47:0] frame;
        logic [31:0] res;
        logic [39:0] tx;
        int          ntx;
        int          nerr;
        int          nstart;
        logic [31:0] opnd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int base;
        int s0;
        int e0;
        int d0;

        vecs[0] = '{48'hA5_78_56_34_12_08, 32'hCAFEBABE, 40'h5A_BE_BA_FE_CA, 5, 0, 1, 32'h12345678};
        vecs[1] = '{48'hA5_78_56_34_12_09, 32'h00000000, 40'hEE_00_00_00_00, 1, 1, 0, 32'h12345678};
        vecs[2] = '{48'hA5_00_00_00_00_00, 32'hFFFFFFFF, 40'h5A_FF_FF_FF_FF, 5, 0, 1, 32'h00000000};
        vecs[3] = '{48'hA5_A5_A5_A5_A5_00, 32'h01020304, 40'h5A_04_03_02_01, 5, 0, 1, 32'hA5A5A5A5};
        vecs[4] = '{48'hA5_01_02_03_04_04, 32'h80000001, 40'h5A_01_00_00_80, 5, 0, 1, 32'h04030201};
        vecs[5] = '{48'hA5_FF_00_FF_00_FF, 32'h00000000, 40'hEE_00_00_00_00, 1, 1, 0, 32'h04030201};

        reset = 1'b1; s_tick = 1'b0; rx_done_tick = 1'b0; rx_dout = 8'h00;
        inj_cdone = 1'b0; cordic_result = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_tx_start", {63'd0, tx_start}, 64'd0);
        check("rst_cordic_start", {63'd0, cordic_start}, 64'd0);
        check("rst_frame_err", {63'd0, frame_err}, 64'd0);
        check("rst_tx_din", {56'd0, tx_din}, 64'd0);
        check("rst_operand", {32'd0, cordic_operand}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table of complete frames
        for (int v = 0; v < 6; v++) begin
            base = txq.size(); s0 = n_start; e0 = n_err;
            cordic_result = vecs[v].res;
            send_frame(vecs[v].frame);
            wait_idle($sformatf("v%0d", v));
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_operand", v), {32'd0, cordic_operand}, {32'd0, vecs[v].opnd});
            check($sformatf("v%0d_starts", v), 64'(n_start - s0), 64'(vecs[v].nstart));
            check($sformatf("v%0d_errs", v), 64'(n_err - e0), 64'(vecs[v].nerr));
            check_reply($sformatf("v%0d", v), base, vecs[v].tx, vecs[v].ntx);
        end

        // Noise in IDLE before a good frame
        base = txq.size(); s0 = n_start;
        send_byte(8'h00);
        check("noise00_busy", {63'd0, busy}, 64'd0);
        send_byte(8'hFF);
        check("noiseFF_busy", {63'd0, busy}, 64'd0);
        send_byte(8'h5A);
        check("noise5A_busy", {63'd0, busy}, 64'd0);
        cordic_result = 32'h11223344;
        send_byte(8'hA5);
        check("noise_sync_busy", {63'd0, busy}, 64'd1);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12); send_byte(8'h08);
        wait_idle("noise");
        check("noise_starts", 64'(n_start - s0), 64'd1);
        check_reply("noise", base, 40'h5A_44_33_22_11, 5);

        // Timeout after one operand byte
        base = txq.size(); s0 = n_start; e0 = n_err;
        send_byte(8'hA5); send_byte(8'h78);
        s_tick = 1'b1;
        repeat (c_tmo - 1) begin @(posedge clk); #1; end
        check("tmo_pre_busy", {63'd0, busy}, 64'd1);
        check("tmo_pre_err", 64'(n_err - e0), 64'd0);
        @(posedge clk);
        #1;
        check("tmo_frame_err", {63'd0, frame_err}, 64'd1);
        check("tmo_busy", {63'd0, busy}, 64'd0);
        s_tick = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        check("tmo_err_count", 64'(n_err - e0), 64'd1);
        check("tmo_no_tx", 64'(txq.size() - base), 64'd0);
        check("tmo_no_start", 64'(n_start - s0), 64'd0);
        // Recovery with a good frame
        base = txq.size(); s0 = n_start;
        cordic_result = 32'hCAFEBABE;
        send_frame(vecs[0].frame);
        wait_idle("tmo_rec");
        check("tmo_rec_starts", 64'(n_start - s0), 64'd1);
        check_reply("tmo_rec", base, 40'h5A_BE_BA_FE_CA, 5);

        // Byte and expiring tick on the same cycle: byte wins
        base = txq.size(); e0 = n_err;
        send_byte(8'hA5); send_byte(8'h78);
        s_tick = 1'b1;
        repeat (c_tmo - 1) begin @(posedge clk); #1; end
        rx_dout = 8'h56; rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        check("same_frame_err", {63'd0, frame_err}, 64'd0);
        check("same_busy", {63'd0, busy}, 64'd1);
        repeat (c_tmo - 1) begin @(posedge clk); #1; end
        s_tick = 1'b0;
        check("same_busy2", {63'd0, busy}, 64'd1);
        cordic_result = 32'h76543210;
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h08);
        wait_idle("same");
        check("same_errs", 64'(n_err - e0), 64'd0);
        check_reply("same", base, 40'h5A_10_32_54_76, 5);

        // Spurious cordic_done in RX_OPND and rx byte during WAIT
        base = txq.size(); s0 = n_start; e0 = n_err;
        send_byte(8'hA5); send_byte(8'h78);
        cordic_result = 32'hDEADBEEF;
        inj_cdone = 1'b1;
        @(posedge clk);
        #1;
        inj_cdone = 1'b0;
        cordic_result = 32'h0BADF00D;
        send_byte(8'h56); send_byte(8'h34); send_byte(8'h12); send_byte(8'h08);
        @(posedge clk);
        #1;
        send_byte(8'hA5);
        wait_idle("drop");
        repeat (5) begin @(posedge clk); #1; end
        check("drop_stays_idle", {63'd0, busy}, 64'd0);
        check("drop_starts", 64'(n_start - s0), 64'd1);
        check("drop_errs", 64'(n_err - e0), 64'd0);
        check("drop_operand", {32'd0, cordic_operand}, 64'h12345678);
        check_reply("drop", base, 40'h5A_0D_F0_AD_0B, 5);

        // Reset right after the ACK byte completes
        base = txq.size(); d0 = n_txdone;
        cordic_result = 32'h13579BDF;
        send_frame(vecs[0].frame);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (n_txdone != d0) break;
        end
        check("rstr_ack_done", 64'(n_txdone - d0), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rstr_busy", {63'd0, busy}, 64'd0);
        check("rstr_tx_start", {63'd0, tx_start}, 64'd0);
        check("rstr_cordic_start", {63'd0, cordic_start}, 64'd0);
        check("rstr_frame_err", {63'd0, frame_err}, 64'd0);
        check("rstr_tx_din", {56'd0, tx_din}, 64'd0);
        check("rstr_operand", {32'd0, cordic_operand}, 64'd0);
        repeat (30) begin @(posedge clk); #1; end
        check_reply("rstr", base, 40'h5A_00_00_00_00, 1);
        check("rstr_still_idle", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute bound on simulation time
    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: actual=running required=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
